// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, per-frame debounce FSM and a
// single active-low strobe per accepted key press.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV = 50_000,
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned TRIG_LEN = 4
) (
    input  logic       i_CLOCK,
    input  logic       i_CLEAR_ALL,
    input  logic [3:0] i_ROWS,
    output logic [3:0] o_COLS,
    output logic [3:0] o_VALUE,
    output logic       o_TRIG,
    output logic [1:0] o_state
);

    localparam int unsigned DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DEB_W   = $clog2(DEBOUNCE + 1);
    localparam int unsigned TRG_W   = $clog2(TRIG_LEN + 1);
    localparam bit          DEB_ONE = (DEBOUNCE <= 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CONFIRM = 2'b01,
        ST_HELD    = 2'b11,
        ST_RELEASE = 2'b10
    } state_e;

    function automatic logic [3:0] key_code(input logic [3:0] idx);
        case (idx)
            4'd0:    key_code = 4'h1;
            4'd1:    key_code = 4'h2;
            4'd2:    key_code = 4'h3;
            4'd3:    key_code = 4'hA;
            4'd4:    key_code = 4'h4;
            4'd5:    key_code = 4'h5;
            4'd6:    key_code = 4'h6;
            4'd7:    key_code = 4'hB;
            4'd8:    key_code = 4'h7;
            4'd9:    key_code = 4'h8;
            4'd10:   key_code = 4'h9;
            4'd11:   key_code = 4'hC;
            4'd12:   key_code = 4'hE;
            4'd13:   key_code = 4'h0;
            4'd14:   key_code = 4'hF;
            default: key_code = 4'hD;
        endcase
    endfunction

    logic [3:0]       rows_s1_q, rows_s2_q;
    logic [DIV_W-1:0] dwell_q;
    logic [1:0]       col_q;
    logic [3:0]       cols_q;
    logic [15:0]      map_q;

    logic             dwell_end_c, frame_end_c;
    logic [15:0]      col_hits_c, frame_map_c;

    assign dwell_end_c = (dwell_q == DIV_W'(SCAN_DIV - 1));
    assign frame_end_c = dwell_end_c && (col_q == 2'd3);
    // Pressed rows of the current column placed at bit 4*row + col.
    assign col_hits_c  = 16'({~rows_s2_q[3], 3'b000, ~rows_s2_q[2], 3'b000,
                              ~rows_s2_q[1], 3'b000, ~rows_s2_q[0]}) << col_q;
    assign frame_map_c = map_q | col_hits_c;

    // Row synchronizer, column scan and frame map accumulation.
    always_ff @(posedge i_CLOCK) begin
        if (!i_CLEAR_ALL) begin
            rows_s1_q <= 4'hF;
            rows_s2_q <= 4'hF;
            dwell_q   <= '0;
            col_q     <= 2'd0;
            cols_q    <= 4'b1110;
            map_q     <= '0;
        end else begin
            rows_s1_q <= i_ROWS;
            rows_s2_q <= rows_s1_q;
            if (dwell_end_c) begin
                dwell_q <= '0;
                col_q   <= col_q + 2'd1;
                cols_q  <= {cols_q[2:0], cols_q[3]};
                map_q   <= frame_end_c ? 16'h0000 : frame_map_c;
            end else begin
                dwell_q <= dwell_q + DIV_W'(1);
            end
        end
    end

    logic [4:0] hit_cnt_c;
    logic [3:0] hit_idx_c;

    always_comb begin
        hit_cnt_c = 5'd0;
        hit_idx_c = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (frame_map_c[i]) begin
                hit_cnt_c = hit_cnt_c + 5'd1;
                hit_idx_c = 4'(i);
            end
        end
    end

    state_e           state_q, state_d;
    logic [DEB_W-1:0] cnt_q, cnt_d, cnt_inc_c;
    logic [3:0]       cand_q, cand_d;
    logic             accept_q, accept_d;
    logic             none_c, single_c, same_c, held_key_c;

    assign none_c     = (hit_cnt_c == 5'd0);
    assign single_c   = (hit_cnt_c == 5'd1);
    assign same_c     = single_c && (hit_idx_c == cand_q);
    assign held_key_c = frame_map_c[cand_q];
    assign cnt_inc_c  = cnt_q + DEB_W'(1);

    always_ff @(posedge i_CLOCK) begin
        if (!i_CLEAR_ALL) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Debounce transitions, evaluated once per frame.
    always_comb begin
        state_d = state_q;
        if (frame_end_c) begin
            case (state_q)
                ST_IDLE: begin
                    if (single_c) state_d = DEB_ONE ? ST_HELD : ST_CONFIRM;
                end
                ST_CONFIRM: begin
                    if (!same_c)                                  state_d = ST_IDLE;
                    else if (cnt_inc_c == DEB_W'(DEBOUNCE))       state_d = ST_HELD;
                end
                ST_HELD: begin
                    if (none_c) state_d = DEB_ONE ? ST_IDLE : ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (held_key_c)                               state_d = ST_HELD;
                    else if (!none_c)                             state_d = ST_IDLE;
                    else if (cnt_inc_c == DEB_W'(DEBOUNCE))       state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        accept_d = 1'b0;
        if (frame_end_c) begin
            case (state_q)
                ST_IDLE: begin
                    if (single_c) begin
                        cand_d = hit_idx_c;
                        cnt_d  = DEB_W'(1);
                    end
                end
                ST_CONFIRM: if (same_c) cnt_d = cnt_inc_c;
                ST_HELD:    if (none_c) cnt_d = DEB_W'(1);
                ST_RELEASE: if (none_c) cnt_d = cnt_inc_c;
                default:    cnt_d = '0;
            endcase
            accept_d = (state_d == ST_HELD) &&
                       ((state_q == ST_IDLE) || (state_q == ST_CONFIRM));
        end
    end

    always_ff @(posedge i_CLOCK) begin
        if (!i_CLEAR_ALL) begin
            cnt_q    <= '0;
            cand_q   <= 4'd0;
            accept_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            accept_q <= accept_d;
        end
    end

    logic [TRG_W-1:0] trig_cnt_q;
    logic [3:0]       value_q;
    logic             trig_q;

    // Strobe: a new acceptance always restarts the count with the new value.
    always_ff @(posedge i_CLOCK) begin
        if (!i_CLEAR_ALL) begin
            trig_cnt_q <= '0;
            value_q    <= 4'd0;
            trig_q     <= 1'b1;
        end else if (accept_q) begin
            trig_cnt_q <= TRG_W'(TRIG_LEN);
            value_q    <= key_code(cand_q);
            trig_q     <= 1'b0;
        end else if (trig_cnt_q != '0) begin
            trig_cnt_q <= trig_cnt_q - TRG_W'(1);
            trig_q     <= (trig_cnt_q == TRG_W'(1));
        end
    end

    assign o_COLS  = cols_q;
    assign o_VALUE = value_q;
    assign o_TRIG  = trig_q;
    assign o_state = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: behavioural keypad matrix, expected strobe codes
// queued with the stimulus and checked when the DUT strobes.
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEBOUNCE = 3;
    localparam int unsigned TRIG_LEN = 2;
    localparam int unsigned FRAME    = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  rows, cols, value;
    logic        trig;
    logic [1:0]  state;
    logic [15:0] keys;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [3:0]  exp_q[$];
    bit          in_strobe = 1'b0;
    int          strobe_len = 0;
    logic [3:0]  strobe_val = 4'd0;
    int          last_start = -1;
    bit          found;

    keypad_scanner #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE(DEBOUNCE),
        .TRIG_LEN(TRIG_LEN)
    ) dut (
        .i_CLOCK    (clk),
        .i_CLEAR_ALL(rst_n),
        .i_ROWS     (rows),
        .o_COLS     (cols),
        .o_VALUE    (value),
        .o_TRIG     (trig),
        .o_state    (state)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[4*r+c] && !cols[c]) rows[r] = 1'b0;
    end

    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Strobe monitor: pop expected code on each falling o_TRIG, check width and hold.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            in_strobe = 1'b0;
        end else if (!in_strobe && trig === 1'b0) begin
            in_strobe  = 1'b1;
            strobe_len = 1;
            last_start = cyc;
            strobe_val = value;
            check("strobe_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("strobe_code", value, exp_q.pop_front());
        end else if (in_strobe && trig === 1'b0) begin
            strobe_len++;
            check("value_stable", value, strobe_val);
        end else if (in_strobe) begin
            in_strobe = 1'b0;
            check("strobe_len", strobe_len, TRIG_LEN);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cols", cols, 4'b1110);
        check("rst_value", value, 4'h0);
        check("rst_trig", trig, 1'b1);
        check("rst_state", state, 2'b00);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_frames(input int n);
        repeat (n * FRAME) @(negedge clk);
    endtask

    task automatic drained(input string tag);
        check(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        keys  = 16'h0;

        // Key B held from reset release: strobe one cycle after frame 3.
        keys[7] = 1'b1;
        exp_q.push_back(4'hB);
        do_reset();
        run_frames(6);
        keys = 16'h0;
        run_frames(5);
        drained("s1_drained");
        check("s1_value", value, 4'hB);
        check("s1_start", last_start, 3 * FRAME + 1);
        check("s1_state", state, 2'b00);

        // Short presses of D never reach DEBOUNCE frames.
        keys = 16'h0;
        do_reset();
        keys[15] = 1'b1; run_frames(2);
        keys = 16'h0;    run_frames(1);
        keys[15] = 1'b1; run_frames(2);
        keys = 16'h0;    run_frames(3);
        drained("s2_drained");
        check("s2_value", value, 4'h0);
        check("s2_state", state, 2'b00);

        // 5 held, 9 added (ignored), release, then 9 alone.
        keys = 16'h0;
        do_reset();
        exp_q.push_back(4'h5);
        exp_q.push_back(4'h9);
        keys[5] = 1'b1;  run_frames(5);
        keys[10] = 1'b1; run_frames(3);
        check("s3_held", state, 2'b11);
        check("s3_value5", value, 4'h5);
        keys = 16'h0;    run_frames(4);
        check("s3_idle", state, 2'b00);
        keys[10] = 1'b1; run_frames(5);
        keys = 16'h0;    run_frames(4);
        drained("s3_drained");
        check("s3_value9", value, 4'h9);

        // Two keys together from IDLE: always MULTI, FSM stays idle.
        keys = 16'h0;
        do_reset();
        keys[0] = 1'b1;
        keys[5] = 1'b1;
        for (int f = 0; f < 5; f++) begin
            run_frames(1);
            check("s4_state", state, 2'b00);
        end
        keys = 16'h0;
        run_frames(1);
        drained("s4_drained");
        check("s4_value", value, 4'h0);

        // Reset during key 7 strobe, key kept held: fresh full confirmation.
        keys = 16'h0;
        keys[8] = 1'b1;
        exp_q.push_back(4'h7);
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge clk);
            if (trig === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        check("s5_strobe_seen", found, 1'b1);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("s5_trig_rst", trig, 1'b1);
        check("s5_value_rst", value, 4'h0);
        check("s5_state_rst", state, 2'b00);
        exp_q.push_back(4'h7);
        #1 rst_n = 1'b1;
        run_frames(5);
        keys = 16'h0;
        run_frames(4);
        drained("s5_drained");
        check("s5_start", last_start, 3 * FRAME + 1);
        check("s5_value", value, 4'h7);

        // Bouncing key A for two frames, then stable.
        keys = 16'h0;
        do_reset();
        exp_q.push_back(4'hA);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i % 3 == 0) keys[3] = ~keys[3];
            @(negedge clk);
        end
        keys[3] = 1'b1;
        run_frames(5);
        keys = 16'h0;
        run_frames(4);
        drained("s6_drained");
        check("s6_value", value, 4'hA);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
